wb_port_arbiter: RTL

Writeback-side driver of the CPU register file's single write port. Merges single-cycle ALU results with handshaked results from a multi-cycle unit (load/multiply), buffers the latter in a small queue, and presents one registered write (enable, address, data) per cycle. Sits between execute/memory and the register file, opposite the decode-side read ports.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_result_queue.sv | 87 ++++++++
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and the result-queue entry layout for the writeback arbiter.
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] WB_REG_ZERO = 5'd0;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_queue.sv
// wb_result_queue: circular buffer of multi-cycle results with per-entry live bits.
// A kill request clears the live bit of every entry whose destination matches.
module wb_result_queue
  import wb_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int AW     = WB_AW,
  parameter int DW     = WB_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_push_live,
  input  logic [AW-1:0]             i_push_rd,
  input  logic [DW-1:0]             i_push_data,
  input  logic                      i_pop,
  input  logic                      i_kill,
  input  logic [AW-1:0]             i_kill_rd,
  output logic                      o_head_live,
  output logic [AW-1:0]             o_head_rd,
  output logic [DW-1:0]             o_head_data,
  output logic [$clog2(QDEPTH):0]   o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [QDEPTH-1:0]         o_live,
  output logic [QDEPTH*AW-1:0]      o_rd
);
  localparam int PW = $clog2(QDEPTH);

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;
  logic [QDEPTH-1:0] r_live;
  logic [AW-1:0]     r_rd   [QDEPTH];
  logic [DW-1:0]     r_data [QDEPTH];

  // Pointers, occupancy and live bits; a popped slot is cleared so it never reads as pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
      r_live  <= {QDEPTH{1'b0}};
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (i_kill && (r_rd[i] == i_kill_rd)) r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      if (i_push) begin
        r_live[r_tail] <= i_push_live;
        r_tail         <= r_tail + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push && !rst) begin
      r_rd[r_tail]   <= i_push_rd;
      r_data[r_tail] <= i_push_data;
    end
  end

  // Head view, status flags and a flattened snapshot of destinations for address matching.
  always_comb begin
    o_head_live = r_live[r_head];
    o_head_rd   = r_rd[r_head];
    o_head_data = r_data[r_head];
    o_count     = r_count;
    o_full      = (r_count == (PW+1)'(QDEPTH));
    o_empty     = (r_count == {(PW+1){1'b0}});
    o_live      = r_live;
    o_rd        = {(QDEPTH*AW){1'b0}};
    for (int i = 0; i < QDEPTH; i++) begin
      o_rd[i*AW +: AW] = r_rd[i];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: drives the single register-file write port, ALU results first, then queued
// multi-cycle results. Decode bypass/pending outputs exist only when WB_BYPASS_EN is defined.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int AW     = WB_AW,
  parameter int DW     = WB_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [AW-1:0]           alu_rd,
  input  logic [DW-1:0]           alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [AW-1:0]           mem_rd,
  input  logic [DW-1:0]           mem_data,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [DW-1:0]           wr_data,
  output logic [$clog2(QDEPTH):0] q_count,
  input  logic [AW-1:0]           rs,
  input  logic [AW-1:0]           rt,
  output logic                    rs_fwd_valid,
  output logic                    rt_fwd_valid,
  output logic [DW-1:0]           rs_fwd_data,
  output logic [DW-1:0]           rt_fwd_data,
  output logic                    rs_pending,
  output logic                    rt_pending
);
  localparam logic [AW-1:0] ZERO_RD = AW'(WB_REG_ZERO);

  logic                    w_full;
  logic                    w_empty;
  logic                    w_mem_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_kill;
  logic                    w_push_live;
  logic                    w_head_live;
  logic [AW-1:0]           w_head_rd;
  logic [DW-1:0]           w_head_data;
  logic [QDEPTH-1:0]       w_live;
  logic [QDEPTH*AW-1:0]    w_rd;
  logic [$clog2(QDEPTH):0] w_count;
  logic                    r_wr_en;
  logic [AW-1:0]           r_wr_addr;
  logic [DW-1:0]           r_wr_data;

  // An ALU write is younger than any queued result, so same-address queued results must never land.
  always_comb begin
    w_mem_ready = !rst && !w_full;
    w_push      = mem_valid && w_mem_ready;
    w_pop       = !alu_valid && !w_empty;
    w_kill      = alu_valid && (alu_rd != ZERO_RD);
    w_push_live = !(w_kill && (mem_rd == alu_rd));
  end

  wb_result_queue #(
    .QDEPTH (QDEPTH),
    .AW     (AW),
    .DW     (DW)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_live (w_push_live),
    .i_push_rd   (mem_rd),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_kill      (w_kill),
    .i_kill_rd   (alu_rd),
    .o_head_live (w_head_live),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_live      (w_live),
    .o_rd        (w_rd)
  );

  // Registered write stage; address/data hold when nothing is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {AW{1'b0}};
      r_wr_data <= {DW{1'b0}};
    end else if (alu_valid) begin
      r_wr_en   <= (alu_rd != ZERO_RD);
      r_wr_addr <= alu_rd;
      r_wr_data <= alu_data;
    end else if (!w_empty) begin
      r_wr_en   <= w_head_live && (w_head_rd != ZERO_RD);
      r_wr_addr <= w_head_rd;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign mem_ready = w_mem_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign q_count   = w_count;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write and flag live queued results that decode must wait for.
  always_comb begin
    rs_fwd_valid = r_wr_en && (r_wr_addr == rs) && (rs != ZERO_RD);
    rt_fwd_valid = r_wr_en && (r_wr_addr == rt) && (rt != ZERO_RD);
    rs_fwd_data  = r_wr_data;
    rt_fwd_data  = r_wr_data;
    rs_pending   = 1'b0;
    rt_pending   = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      rs_pending = rs_pending | (w_live[i] && (w_rd[i*AW +: AW] == rs) && (rs != ZERO_RD));
      rt_pending = rt_pending | (w_live[i] && (w_rd[i*AW +: AW] == rt) && (rt != ZERO_RD));
    end
  end
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{rs, rt, w_live, w_rd};
  assign rs_fwd_valid    = 1'b0;
  assign rt_fwd_valid    = 1'b0;
  assign rs_fwd_data     = {DW{1'b0}};
  assign rt_fwd_data     = {DW{1'b0}};
  assign rs_pending      = 1'b0;
  assign rt_pending      = 1'b0;
`endif

endmodule
